// File: rtl/nibble_add_pkg.sv
// rtl/nibble_add_pkg.sv - shared state encoding, slice width and nibble count helper
package nibble_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SLICE_W = 4;

  function automatic int nib_count(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/nibble_add_scheduler_add4_slice.sv
// rtl/nibble_add_scheduler_add4_slice.sv - combinational 4-bit adder slice shared by both requesters
module add4_slice
  import nibble_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] sum_o,
  output logic               cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SLICE_W{1'b0}}, cin_i};

endmodule

// File: rtl/nibble_add_scheduler.sv
// rtl/nibble_add_scheduler.sv - round-robin arbiter feeding one nibble-serial adder slice
module nibble_add_scheduler
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_carry,
  output logic             rsp_id,
  output logic             busy
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
    $error("nibble_add_scheduler: WIDTH must be a positive multiple of 4");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic               carry_q, carry_d, id_q, id_d, last_q, last_d;
  logic               grant;
  logic [SLICE_W-1:0] nib_a, nib_b, nib_sum;
  logic               nib_cout;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_q;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = rst_n && (state_q == IDLE) && req0_valid && !grant;
  assign req1_ready = rst_n && (state_q == IDLE) && req1_valid &&  grant;

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_a = a_q[i*SLICE_W +: SLICE_W];
        nib_b = b_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  add4_slice u_slice (
    .a_i    (nib_a),
    .b_i    (nib_b),
    .cin_i  (carry_q),
    .sum_o  (nib_sum),
    .cout_o (nib_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    id_d    = id_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          a_d     = grant ? req1_a   : req0_a;
          b_d     = grant ? req1_b   : req0_b;
          carry_d = grant ? req1_cin : req0_cin;
          idx_d   = '0;
          id_d    = grant;
          last_d  = grant;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NIB; i++) begin
          if (idx_q == IDX_W'(i)) sum_d[i*SLICE_W +: SLICE_W] = nib_sum;
        end
        carry_d = nib_cout;
        if (idx_q == IDX_W'(NIB - 1)) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_sum   = sum_q;
  assign rsp_carry = carry_q;
  assign rsp_id    = id_q;

endmodule
